// File: rtl/sobel_pkg.sv
// Shared types and helpers for the SobelX frame sequencer.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Round a row width up to the next multiple of 4 bytes (BMP row stride).
  function automatic logic [16:0] stride_round(input logic [15:0] width);
    logic [16:0] sum;
    sum = {1'b0, width} + 17'd3;
    return {sum[16:2], 2'b00};
  endfunction

endpackage

// File: rtl/sobel_tok_pipe.sv
// Token shift register that mirrors the SobelX pipeline: each stage carries
// {valid, pad} for the pixel currently occupying that filter stage.
module sobel_tok_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_valid,
  input  logic in_pad,
  output logic out_valid,
  output logic out_pad
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] pad_q, pad_d;

  // Shift one stage per enabled cycle; hold otherwise.
  always_comb begin
    vld_d = vld_q;
    pad_d = pad_q;
    if (en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        pad_d[i] = pad_q[i-1];
      end
      vld_d[0] = in_valid;
      pad_d[0] = in_pad;
    end else begin
      vld_d = vld_q;
      pad_d = pad_q;
    end
  end

  // Token state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      pad_q <= '0;
    end else begin
      vld_q <= vld_d;
      pad_q <= pad_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_pad   = pad_q[DEPTH-1];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: reads a padded 8bpp pixel array, streams it through
// SobelX and writes saturated results (pads forced to zero) to memory.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int ADDR_W   = 21,
  parameter int DIM_W    = 12,
  parameter int PIPE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              sx_en,
  output logic [31:0]       sx_data,
  input  logic [31:0]       sx_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = 2 * DIM_W + 1;
  localparam int STR_W = DIM_W + 1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
  logic [DIM_W-1:0]   width_q, width_d;
  logic [STR_W-1:0]   stride_q, stride_d, col_q, col_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d, push_cnt_q, push_cnt_d, wr_cnt_q, wr_cnt_d;
  logic               inflight_q, inflight_d, pix_vld_q, pix_vld_d;
  logic [PIX_W-1:0]   pix_q, pix_d;

  logic               in_run_s, in_drain_s, avail_s, push_s;
  logic               rd_en_s, sx_en_s, wr_en_s;
  logic               tok_valid_s, tok_pad_s, pad_in_s;
  logic [PIX_W-1:0]   pix_s;
  logic [STR_W-1:0]   stride_s;
  logic [CNT_W-1:0]   total_s;

  assign in_run_s   = (state_q == S_RUN);
  assign in_drain_s = (state_q == S_DRAIN);
  // A pixel is available either parked in the skid or landing from the read issued last cycle.
  assign avail_s    = pix_vld_q | inflight_q;
  assign pix_s      = pix_vld_q ? pix_q : rd_data;
  assign pad_in_s   = (col_q >= {1'b0, width_q});
  assign stride_s   = STR_W'(stride_round(16'(img_width)));
  assign total_s    = CNT_W'(stride_s) * CNT_W'(img_height);

  // Strobes: push only when the tail token can leave, reads only when the skid has room.
  always_comb begin
    sx_en_s = 1'b0;
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    if (rst) begin
      sx_en_s = 1'b0;
      rd_en_s = 1'b0;
      wr_en_s = 1'b0;
    end else begin
      if (in_run_s) begin
        sx_en_s = avail_s & (~tok_valid_s | wr_ready);
      end else if (in_drain_s) begin
        sx_en_s = ~tok_valid_s | wr_ready;
      end else begin
        sx_en_s = 1'b0;
      end
      rd_en_s = in_run_s & (rd_cnt_q < total_q) & (~avail_s | sx_en_s);
      wr_en_s = tok_valid_s & wr_ready;
    end
  end

  assign push_s = in_run_s & sx_en_s;

  sobel_tok_pipe #(.DEPTH(PIPE_LAT)) u_tok_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (sx_en_s),
    .in_valid  (push_s),
    .in_pad    (push_s & pad_in_s),
    .out_valid (tok_valid_s),
    .out_pad   (tok_pad_s)
  );

  // Next-state: FSM, counters, geometry capture and skid register.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    width_d    = width_q;
    stride_d   = stride_q;
    total_d    = total_q;
    inflight_d = rd_en_s;
    rd_cnt_d   = rd_cnt_q + CNT_W'(rd_en_s);
    push_cnt_d = push_cnt_q + CNT_W'(push_s);
    wr_cnt_d   = wr_cnt_q + CNT_W'(wr_en_s);
    col_d      = col_q;
    pix_vld_d  = pix_vld_q;
    pix_d      = pix_q;

    if (push_s) begin
      col_d = (col_q + STR_W'(1) == stride_q) ? STR_W'(0) : col_q + STR_W'(1);
    end else begin
      col_d = col_q;
    end

    // Park landing read data only if it was not consumed directly.
    if (pix_vld_q && push_s) begin
      pix_vld_d = 1'b0;
    end else if (inflight_q && !pix_vld_q && !push_s) begin
      pix_vld_d = 1'b1;
      pix_d     = rd_data;
    end else begin
      pix_vld_d = pix_vld_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d      = src_base;
          dst_d      = dst_base;
          width_d    = img_width;
          stride_d   = stride_s;
          total_d    = total_s;
          rd_cnt_d   = CNT_W'(0);
          push_cnt_d = CNT_W'(0);
          wr_cnt_d   = CNT_W'(0);
          col_d      = STR_W'(0);
          pix_vld_d  = 1'b0;
          if (img_width == DIM_W'(0) || img_height == DIM_W'(0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (push_s && (push_cnt_q == total_q - CNT_W'(1))) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (wr_en_s && (wr_cnt_q == total_q - CNT_W'(1))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      width_q    <= '0;
      stride_q   <= '0;
      total_q    <= '0;
      rd_cnt_q   <= '0;
      push_cnt_q <= '0;
      wr_cnt_q   <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
      pix_vld_q  <= 1'b0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      width_q    <= width_d;
      stride_q   <= stride_d;
      total_q    <= total_d;
      rd_cnt_q   <= rd_cnt_d;
      push_cnt_q <= push_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      col_q      <= col_d;
      inflight_q <= inflight_d;
      pix_vld_q  <= pix_vld_d;
      pix_q      <= pix_d;
    end
  end

  assign rd_en   = rd_en_s;
  assign rd_addr = src_q + ADDR_W'(rd_cnt_q);
  assign sx_en   = sx_en_s;
  assign sx_data = (in_run_s && avail_s) ? {24'd0, pix_s} : 32'd0;
  assign wr_en   = wr_en_s;
  assign wr_addr = dst_q + ADDR_W'(wr_cnt_q);
  assign wr_data = (!tok_valid_s || tok_pad_s) ? 8'd0 :
                   ((sx_result > 32'd255) ? 8'd255 : sx_result[7:0]);
  assign busy    = in_run_s | in_drain_s;
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, wr_ready;
  logic [20:0] src_base, dst_base, rd_addr, wr_addr;
  logic [11:0] img_width, img_height;
  logic        rd_en, sx_en, wr_en, busy, done;
  logic [7:0]  rd_data, wr_data;
  logic [31:0] sx_data, sx_result;

  typedef struct {
    logic [20:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         sb[$];
  logic [7:0]  src_mem [256];
  int          sx_mode;
  int          tests_run = 0;
  int          tests_failed = 0;

  sobel_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .img_width(img_width), .img_height(img_height), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .sx_en(sx_en), .sx_data(sx_data), .sx_result(sx_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_sx(input int mode, input logic [7:0] p);
    if (mode == 1) begin
      case (p)
        8'd0:    return 32'd300;
        8'd1:    return 32'd255;
        8'd2:    return 32'd17;
        8'd3:    return 32'd256;
        default: return {24'd0, p};
      endcase
    end
    return {24'd0, p};
  endfunction

  function automatic logic rdy_of(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (k < 4) return 1'b1;
    if (k <= 9) return 1'b0;
    return ((k - 10) % 2) == 0;
  endfunction

  // Source memory (1-cycle read) and a 1-stage SobelX stand-in.
  always @(posedge clk) begin
    if (rd_en) rd_data <= src_mem[rd_addr[7:0]];
    if (sx_en) sx_result <= tb_sx(sx_mode, sx_data[7:0]);
  end

  task automatic run_frame(input int w, input int h, input logic [20:0] s, input logic [20:0] d,
                           input int rdy_mode, input int restart_at, input int abort_at,
                           output int done_cyc, output int nwr, output int nstrobe);
    int    k, pushes, outstanding, stride, total, col, idx;
    bit    fin, exp_wr;
    logic [31:0] v;
    wr_t   e, got;
    stride = (w + 3) / 4 * 4;
    total  = stride * h;
    sb.delete();
    for (int i = 0; i < total; i++) begin
      col = i % stride;
      idx = (int'(s) + i) % 256;
      v = tb_sx(sx_mode, src_mem[idx]);
      e.addr = d + 21'(i);
      if (col >= w) e.data = 8'd0;
      else if (v > 32'd255) e.data = 8'd255;
      else e.data = v[7:0];
      sb.push_back(e);
    end
    done_cyc = -1; nwr = 0; nstrobe = 0; pushes = 0; fin = 0; k = 0;
    @(posedge clk); #1;
    src_base = s; dst_base = d; img_width = 12'(w); img_height = 12'(h);
    start = 1'b1; wr_ready = 1'b1;
    while (!fin) begin
      @(posedge clk); #1;
      k++;
      start    = (k == restart_at);
      wr_ready = rdy_of(rdy_mode, k);
      @(negedge clk);
      outstanding = ((pushes < total) ? pushes : total) - nwr;
      exp_wr = (outstanding > 0) && wr_ready;
      tests_run++;
      if (wr_en !== exp_wr) begin
        tests_failed++;
        $display("FAIL wr_en_flow cycle %0d: got %b want %b", k, wr_en, exp_wr);
      end
      if (outstanding > 0 && !wr_ready) begin
        tests_run++;
        if (sx_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_freeze cycle %0d: sx_en got %b want 0", k, sx_en);
        end
      end
      if (rd_en || sx_en || wr_en) nstrobe++;
      if (wr_en === 1'b1) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL extra_write cycle %0d: addr %0d data %0d, want none", k, wr_addr, wr_data);
        end else begin
          got = sb.pop_front();
          if (wr_addr !== got.addr || wr_data !== got.data) begin
            tests_failed++;
            $display("FAIL write_%0d: got addr %0d data %0d want addr %0d data %0d",
                     nwr, wr_addr, wr_data, got.addr, got.data);
          end
        end
        nwr++;
      end
      if (sx_en === 1'b1) pushes++;
      if (done === 1'b1) begin
        done_cyc = k; fin = 1;
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL busy_at_done: got %b want 0", busy);
        end
      end
      if (abort_at > 0 && nwr == abort_at) fin = 1;
      if (k >= 400) begin
        tests_run++; tests_failed++;
        $display("FAIL timeout: no done after %0d cycles", k);
        fin = 1;
      end
    end
    start = 1'b0; wr_ready = 1'b1;
    if (abort_at == 0) begin
      tests_run++;
      if (sb.size() != 0) begin
        tests_failed++;
        $display("FAIL missing_writes: got %0d left want 0", sb.size());
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
    src_base = '0; dst_base = '0; img_width = '0; img_height = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({rd_en, sx_en, wr_en, busy, done, rd_addr, wr_addr, sx_data, wr_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rd%b sx%b wr%b busy%b done%b ra%0d wa%0d sd%0d wd%0d want all 0",
               rd_en, sx_en, wr_en, busy, done, rd_addr, wr_addr, sx_data, wr_data);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done, rd_en} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy%b done%b rd%b want 000", busy, done, rd_en);
    end
  endtask

  task automatic test_basic;
    int dc, n, ns;
    sx_mode = 0;
    run_frame(4, 2, 21'd10, 21'd100, 0, 0, 0, dc, n, ns);
    tests_run++;
    if (n != 8 || dc != 11) begin
      tests_failed++;
      $display("FAIL basic_frame: got %0d writes done@%0d want 8 done@11", n, dc);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_after: got busy%b done%b want 00", busy, done);
    end
  endtask

  task automatic test_padding;
    int dc, n, ns;
    run_frame(3, 2, 21'd40, 21'd200, 0, 0, 0, dc, n, ns);
    tests_run++;
    if (n != 8) begin
      tests_failed++;
      $display("FAIL pad_frame: got %0d writes want 8", n);
    end
  endtask

  task automatic test_backpressure;
    int dc, n, ns;
    run_frame(4, 4, 21'd0, 21'd300, 1, 0, 0, dc, n, ns);
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("FAIL backpressure_frame: got %0d writes want 16", n);
    end
  endtask

  task automatic test_saturation;
    int dc, n, ns;
    for (int i = 0; i < 4; i++) src_mem[60 + i] = 8'(i);
    sx_mode = 1;
    run_frame(4, 1, 21'd60, 21'd400, 0, 0, 0, dc, n, ns);
    sx_mode = 0;
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL saturation_frame: got %0d writes want 4", n);
    end
  endtask

  task automatic test_zero_dims;
    int dc, n, ns;
    run_frame(4, 0, 21'd5, 21'd600, 0, 0, 0, dc, n, ns);
    tests_run++;
    if (dc != 1 || ns != 0 || n != 0) begin
      tests_failed++;
      $display("FAIL zero_dims: got done@%0d strobes %0d writes %0d want done@1 0 0", dc, ns, n);
    end
  endtask

  task automatic test_start_while_busy;
    int dc, n, ns;
    run_frame(4, 2, 21'd10, 21'd700, 0, 5, 0, dc, n, ns);
    tests_run++;
    if (n != 8 || dc != 11) begin
      tests_failed++;
      $display("FAIL start_while_busy: got %0d writes done@%0d want 8 done@11", n, dc);
    end
  endtask

  task automatic test_reset_abort;
    int dc, n, ns;
    run_frame(4, 4, 21'd0, 21'd500, 0, 0, 5, dc, n, ns);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({rd_en, sx_en, wr_en} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_strobes: got rd%b sx%b wr%b want 000", rd_en, sx_en, wr_en);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rd_en, sx_en, wr_en, busy, done, rd_addr, wr_addr, sx_data, wr_data} !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got rd%b sx%b wr%b busy%b done%b ra%0d wa%0d sd%0d wd%0d want all 0",
               rd_en, sx_en, wr_en, busy, done, rd_addr, wr_addr, sx_data, wr_data);
    end
    run_frame(4, 4, 21'd0, 21'd500, 0, 0, 0, dc, n, ns);
    tests_run++;
    if (n != 16 || dc != 19) begin
      tests_failed++;
      $display("FAIL restart_after_abort: got %0d writes done@%0d want 16 done@19", n, dc);
    end
  endtask

  initial begin
    sx_mode = 0;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'((i * 7 + 3) % 256);
    test_reset();
    test_basic();
    test_padding();
    test_backpressure();
    test_saturation();
    test_zero_dims();
    test_start_while_busy();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
